serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_pkg.sv | 13 +
 rtl/fa_cell.sv | 14 +
 rtl/serial_adder_ctrl.sv | 107 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder controller: FSM encoding and default operand width.
// Purely declarative; no latency or flow-control of its own.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder shared by every bit position of the serial adder.
// Combinational, zero latency, no flow control.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial a+b+cin, LSB first, one bit per clock; out_valid rises WIDTH+1 edges after accept.
// Valid/ready on both sides: no new operands are taken until the result has been handed off.
module serial_adder_ctrl #(
    parameter int WIDTH = serial_adder_pkg::DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    import serial_adder_pkg::*;

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state_q, state_d;
    logic               init_q;
    logic               vld_q;
    logic [WIDTH-1:0]   a_q, b_q, sum_q;
    logic               carry_q, cout_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               accept, last_bit, handoff;
    logic               fa_s, fa_co;

    assign accept   = in_valid && in_ready;
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    assign handoff  = (state_q == ST_DONE) && vld_q && out_ready;

    fa_cell u_fa (
        .x  (a_q[cnt_q]),
        .y  (b_q[cnt_q]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)   state_d = ST_ADD;
            ST_ADD:  if (last_bit) state_d = ST_DONE;
            ST_DONE: if (handoff)  state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    // init_q holds in_ready low until the first edge after reset release.
    always_comb begin
        in_ready  = (state_q == ST_IDLE) && init_q;
        busy      = (state_q == ST_ADD);
        out_valid = vld_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q  <= 1'b0;
            vld_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            init_q <= 1'b1;
            // Result is presented one edge after entering DONE, giving WIDTH+1 edges of latency.
            vld_q  <= (state_q == ST_DONE) && (state_d == ST_DONE);
            if (accept) begin
                a_q     <= a;
                b_q     <= b;
                carry_q <= cin;
                sum_q   <= '0;
                cout_q  <= 1'b0;
                cnt_q   <= '0;
            end else if (state_q == ST_ADD) begin
                sum_q[cnt_q] <= fa_s;
                carry_q      <= fa_co;
                if (last_bit) begin
                    cout_q <= fa_co;
                    cnt_q  <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench: drivers queue expected results on accept, monitors compare on out_valid rise.
// Covers directed WIDTH=8 vectors, DONE stall, mid-ADD reset and an exhaustive WIDTH=4 sweep.
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       iv8, ir8, ov8, or8, cin8, co8, busy8;
    logic [7:0] a8, b8, s8;
    logic       iv4, ir4, ov4, or4, cin4, co4, busy4;
    logic [3:0] a4, b4, s4;

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(cin8),
        .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .busy(busy8)
    );

    serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .cin(cin4),
        .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4), .busy(busy4)
    );

    typedef struct {
        logic [7:0] s;
        logic       c;
        int         acc;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];
    exp_t e8, e4;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    logic ov8_prev = 1'b0;
    logic ov4_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (ov8 && !ov8_prev) begin
            if (q8.size() == 0) begin
                check("u8 out_valid with no pending op", 32'(ov8), 32'd0);
            end else begin
                e8 = q8.pop_front();
                check("u8 sum", 32'(s8), 32'(e8.s));
                check("u8 cout", 32'(co8), 32'(e8.c));
                check("u8 latency", 32'(cyc - e8.acc), 32'd9);
            end
        end
        ov8_prev = ov8;
    end

    always @(negedge clk) begin
        if (ov4 && !ov4_prev) begin
            if (q4.size() == 0) begin
                check("u4 out_valid with no pending op", 32'(ov4), 32'd0);
            end else begin
                e4 = q4.pop_front();
                check("u4 sum", 32'(s4), 32'(e4.s));
                check("u4 cout", 32'(co4), 32'(e4.c));
                check("u4 latency", 32'(cyc - e4.acc), 32'd5);
            end
        end
        ov4_prev = ov4;
    end

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input bit push, input logic [7:0] es, input logic ec);
        int n = 0;
        while (!ir8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ir8) begin
            check("u8 in_ready wait", 32'(ir8), 32'd1);
            return;
        end
        a8 = a; b8 = b; cin8 = c; iv8 = 1'b1;
        @(posedge clk);
        #1;
        if (push) q8.push_back('{es, ec, cyc});
        @(negedge clk);
        iv8 = 1'b0;
    endtask

    task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic c,
                         input logic [3:0] es, input logic ec);
        int n = 0;
        while (!ir4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ir4) begin
            check("u4 in_ready wait", 32'(ir4), 32'd1);
            return;
        end
        a4 = a; b4 = b; cin4 = c; iv4 = 1'b1;
        @(posedge clk);
        #1;
        q4.push_back('{{4'h0, es}, ec, cyc});
        @(negedge clk);
        iv4 = 1'b0;
    endtask

    task automatic drain8();
        int n = 0;
        while (q8.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("u8 drain", 32'(q8.size()), 32'd0);
    endtask

    task automatic drain4();
        int n = 0;
        while (q4.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("u4 drain", 32'(q4.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int n;
        rst_n = 1'b0;
        iv8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; or8 = 1'b1;
        iv4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; or4 = 1'b1;

        repeat (2) @(negedge clk);
        check("reset in_ready", 32'(ir8), 32'd0);
        check("reset out_valid", 32'(ov8), 32'd0);
        check("reset busy", 32'(busy8), 32'd0);
        check("reset sum", 32'(s8), 32'd0);
        check("reset cout", 32'(co8), 32'd0);
        rst_n = 1'b1;
        #1;
        check("in_ready before first edge", 32'(ir8), 32'd0);
        @(posedge clk);
        #1;
        check("in_ready after first edge", 32'(ir8), 32'd1);
        @(negedge clk);

        send8(8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
        send8(8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1);
        send8(8'hA5, 8'h5A, 1'b1, 1'b1, 8'h00, 1'b1);
        send8(8'h3C, 8'h42, 1'b0, 1'b1, 8'h7E, 1'b0);
        send8(8'h80, 8'h80, 1'b1, 1'b1, 8'h01, 1'b1);
        drain8();

        // Consumer stalls in DONE while a second operand set is offered.
        or8 = 1'b0;
        send8(8'hC3, 8'h3C, 1'b0, 1'b1, 8'hFF, 1'b0);
        n = 0;
        while (!ov8 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("stall out_valid rise", 32'(ov8), 32'd1);
        iv8 = 1'b1; a8 = 8'h11; b8 = 8'h22; cin8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall out_valid", 32'(ov8), 32'd1);
            check("stall sum", 32'(s8), 32'hFF);
            check("stall cout", 32'(co8), 32'd0);
            check("stall in_ready", 32'(ir8), 32'd0);
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        @(negedge clk);
        check("post-handoff out_valid", 32'(ov8), 32'd0);
        check("post-handoff in_ready", 32'(ir8), 32'd1);
        check("post-handoff busy", 32'(busy8), 32'd0);

        // Reset in the middle of ADD: nothing may be presented.
        send8(8'h11, 8'h22, 1'b0, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        repeat (3) @(posedge clk);
        #2;
        check("mid-add busy", 32'(busy8), 32'd1);
        check("mid-add partial sum", 32'(s8), 32'h03);
        rst_n = 1'b0;
        #1;
        check("abort in_ready", 32'(ir8), 32'd0);
        check("abort out_valid", 32'(ov8), 32'd0);
        check("abort busy", 32'(busy8), 32'd0);
        check("abort sum", 32'(s8), 32'd0);
        check("abort cout", 32'(co8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send8(8'h01, 8'h01, 1'b0, 1'b1, 8'h02, 1'b0);
        drain8();

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    t = a + b + c;
                    send4(4'(a), 4'(b), 1'(c), 4'(t), 1'(t >> 4));
                end
            end
        end
        drain4();
        repeat (12) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
